dmem_responder: RTL



---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_array.sv | 38 +++
 rtl/dmem_responder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the CPU data-memory responder.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 5;
  localparam int DMEM_DATA_W = 32;
  localparam int WAIT_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed register array: one synchronous write port, two combinational
// read ports (transaction path and debug side port), cleared on reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage update: whole array cleared on reset, single write port otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DATA_W'(0);
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata     = mem[raddr];
  assign dbg_rdata = mem[dbg_addr];

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the CPU data-memory interface: request/response handshakes
// with programmable wait states, plus a debug read port and access counter.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = DMEM_ADDR_W,
  parameter int DATA_W      = DMEM_DATA_W,
  parameter int WAIT_CYCLES = 1,
  parameter int CNT_W       = 10
) (
  input  logic              clk_150MHz,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [CNT_W-1:0]  access_count
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);

  dmem_state_e             state;
  dmem_state_e             next_state;
  logic                    cap_we;
  logic [ADDR_W-1:0]       cap_addr;
  logic [DATA_W-1:0]       cap_wdata;
  logic [WAIT_CNT_W-1:0]   wait_cnt;
  logic                    access_now;
  logic                    mem_we;
  logic [DATA_W-1:0]       mem_rdata;

  // The access happens on the last WAIT edge, so a write lands before the next acceptance.
  assign access_now = (state == WAIT) && (wait_cnt == WAIT_CNT_W'(0));
  assign mem_we     = access_now && cap_we;

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk       (clk_150MHz),
    .reset     (reset),
    .we        (mem_we),
    .waddr     (cap_addr),
    .wdata     (cap_wdata),
    .raddr     (cap_addr),
    .rdata     (mem_rdata),
    .dbg_addr  (dbg_addr),
    .dbg_rdata (dbg_rdata)
  );

  // FSM state register.
  always_ff @(posedge clk_150MHz or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          next_state = WAIT;
        end else begin
          next_state = IDLE;
        end
      end
      WAIT: begin
        if (wait_cnt == WAIT_CNT_W'(0)) begin
          next_state = RESP;
        end else begin
          next_state = WAIT;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          next_state = IDLE;
        end else begin
          next_state = RESP;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Request capture, wait countdown, response data and completion counter.
  always_ff @(posedge clk_150MHz or posedge reset) begin
    if (reset) begin
      cap_we       <= 1'b0;
      cap_addr     <= ADDR_W'(0);
      cap_wdata    <= DATA_W'(0);
      wait_cnt     <= WAIT_CNT_W'(0);
      rsp_we       <= 1'b0;
      rsp_rdata    <= DATA_W'(0);
      access_count <= CNT_W'(0);
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_we    <= req_we;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            wait_cnt  <= WAIT_LOAD;
          end
        end
        WAIT: begin
          if (wait_cnt != WAIT_CNT_W'(0)) begin
            wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
          end else begin
            rsp_we    <= cap_we;
            rsp_rdata <= cap_we ? DATA_W'(0) : mem_rdata;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            access_count <= access_count + CNT_W'(1);
          end
        end
        default: begin
          wait_cnt <= WAIT_CNT_W'(0);
        end
      endcase
    end
  end

endmodule
